// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer
// Job sequencer for the ARRAY_DIM x ARRAY_DIM systolic fp16 PE grid.
// A job clears the PE accumulators and streams K skewed operand indices into
// the grid. It waits for the last product to settle, then hands out results
// one row per res_valid/res_ready handshake.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start, k_len    job request (honoured only in IDLE) and reduction length
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse
//   array_clear     PE-grid accumulator reset
//   feed_en,feed_k  per-lane operand enable and operand index (lane i at
//                   feed_k[i*K_BITS +: K_BITS])
//   res_valid,res_row,res_ready  result-row handshake
//   abort           only when PE_SEQ_ABORT_EN is defined
//
// Build option: define PE_SEQ_ABORT_EN to add the abort port. With it, abort
// in any non-IDLE state runs one clear cycle and returns to IDLE without done.
// All outputs are registered.
module pe_array_sequencer #(
  parameter int ARRAY_DIM  = 4,
  parameter int K_BITS     = 8,
  parameter int PIPE_STAGE = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [K_BITS-1:0]                   k_len,
  output logic                                busy,
  output logic                                done,
  output logic                                array_clear,
  output logic [ARRAY_DIM-1:0]                feed_en,
  output logic [ARRAY_DIM-1:0][K_BITS-1:0]    feed_k,
  output logic                                res_valid,
  output logic [$clog2(ARRAY_DIM)-1:0]        res_row,
  input  logic                                res_ready
`ifdef PE_SEQ_ABORT_EN
  ,
  input  logic                                abort
`endif
);

  localparam int ROW_W = $clog2(ARRAY_DIM);
  // t reaches K+ARRAY_DIM-2 with K up to 2^K_BITS-1; one spare bit means it never wraps
  localparam int T_W   = K_BITS + $clog2(ARRAY_DIM) + 1;
  localparam int C_W   = $clog2(ARRAY_DIM + PIPE_STAGE) + 1;
  localparam logic [C_W-1:0]   DRAIN_LAST = C_W'(ARRAY_DIM - 2 + PIPE_STAGE);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ARRAY_DIM - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, READOUT, DONE} state_t;

  state_t            state;
  logic [K_BITS-1:0] k_q;
  logic [T_W-1:0]    t;
  logic [C_W-1:0]    dcnt;
  logic [T_W-1:0]    feed_last;
`ifdef PE_SEQ_ABORT_EN
  logic              abort_pend;
`endif

  assign feed_last = T_W'(k_q) + T_W'(ARRAY_DIM - 2);

  // Lane i sees operand t-i while i <= t < i+K: the diagonal skew of the grid.
  function automatic logic [ARRAY_DIM-1:0] lane_en(input logic [T_W-1:0] tt,
                                                   input logic [K_BITS-1:0] kk);
    logic [T_W-1:0] d;
    lane_en = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      d = tt - T_W'(i);
      lane_en[i] = (tt >= T_W'(i)) && (d < T_W'(kk));
    end
  endfunction

  function automatic logic [ARRAY_DIM-1:0][K_BITS-1:0] lane_k(input logic [T_W-1:0] tt,
                                                              input logic [K_BITS-1:0] kk);
    logic [T_W-1:0] d;
    lane_k = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      d = tt - T_W'(i);
      if ((tt >= T_W'(i)) && (d < T_W'(kk))) lane_k[i] = d[K_BITS-1:0];
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k_q         <= '0;
      t           <= '0;
      dcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_clear <= 1'b1;  // grid is held clear while the sequencer is reset
      feed_en     <= '0;
      feed_k      <= '0;
      res_valid   <= 1'b0;
      res_row     <= '0;
`ifdef PE_SEQ_ABORT_EN
      abort_pend  <= 1'b0;
`endif
    end
`ifdef PE_SEQ_ABORT_EN
    else if (abort && state != IDLE) begin
      state       <= CLEAR;
      abort_pend  <= 1'b1;
      busy        <= 1'b1;
      done        <= 1'b0;
      array_clear <= 1'b1;
      feed_en     <= '0;
      feed_k      <= '0;
      res_valid   <= 1'b0;
      res_row     <= '0;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          array_clear <= 1'b0;
          if (start) begin
            k_q         <= k_len;
            state       <= CLEAR;
            busy        <= 1'b1;
            array_clear <= 1'b1;
          end
        end
        CLEAR: begin
          array_clear <= 1'b0;
`ifdef PE_SEQ_ABORT_EN
          if (abort_pend) begin
            abort_pend <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else
`endif
          if (k_q != '0) begin
            state   <= FEED;
            t       <= '0;
            feed_en <= lane_en('0, k_q);
            feed_k  <= lane_k('0, k_q);
          end else begin
            // nothing to accumulate: the cleared grid already holds the zero result
            state     <= READOUT;
            res_valid <= 1'b1;
            res_row   <= '0;
          end
        end
        FEED: begin
          if (t == feed_last) begin
            state   <= DRAIN;
            dcnt    <= '0;
            feed_en <= '0;
            feed_k  <= '0;
          end else begin
            t       <= t + T_W'(1);
            feed_en <= lane_en(t + T_W'(1), k_q);
            feed_k  <= lane_k(t + T_W'(1), k_q);
          end
        end
        DRAIN: begin
          // skew to the far corner PE plus the PE multiply/add latency
          if (dcnt == DRAIN_LAST) begin
            state     <= READOUT;
            res_valid <= 1'b1;
            res_row   <= '0;
          end else begin
            dcnt <= dcnt + C_W'(1);
          end
        end
        READOUT: begin
          if (res_ready) begin
            if (res_row == ROW_LAST) begin
              state     <= DONE;
              res_valid <= 1'b0;
              res_row   <= '0;
              done      <= 1'b1;
            end else begin
              res_row <= res_row + ROW_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
